// File: rtl/eco32_core_mpu_cfr_ctl_if.sv
// eco32_core_mpu_cfr_ctl_if: flag-write request bundle (A replace path, B set/clear path).
interface eco32_core_mpu_cfr_ctl_if;
    logic        a_stb;
    logic        a_th;
    logic [15:0] a_flags;
    logic        b_stb;
    logic        b_th;
    logic [15:0] b_set;
    logic [15:0] b_clr;
    logic        b_ack;
    modport master (output a_stb, a_th, a_flags, b_stb, b_th, b_set, b_clr, input b_ack);
    modport slave  (input a_stb, a_th, a_flags, b_stb, b_th, b_set, b_clr, output b_ack);
endinterface

// File: rtl/eco32_core_mpu_cfr_ctl.sv
// eco32_core_mpu_cfr_ctl: slot-aligned write scheduler for the 2-thread interleaved flag ring.
module eco32_core_mpu_cfr_ctl #(
    parameter int B_DEPTH = 4,
    parameter int B_AW    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_cfr_th,
    input  logic [15:0]                i_cfr_flags,
    eco32_core_mpu_cfr_ctl_if.slave    io_req,
    output logic                       o_ia_wen,
    output logic [15:0]                o_ia_flags,
    output logic                       o_ib_wen,
    output logic [15:0]                o_ib_flags,
    output logic                       o_a_ovr,
    output logic [B_AW:0]              o_b_cnt,
    output logic                       o_busy
);
    logic [1:0]      r_a_pend;
    logic [15:0]     r_a_val [2];
    logic [15:0]     r_prev;
    logic            r_a_ovr;
    logic [B_AW-1:0] r_wr;
    logic [B_AW-1:0] r_rd;
    logic [B_AW:0]   r_cnt;
    logic            r_b_th  [B_DEPTH];
    logic [15:0]     r_b_set [B_DEPTH];
    logic [15:0]     r_b_clr [B_DEPTH];

    logic w_s;
    logic w_iss_a;
    logic w_iss_b;
    logic w_empty;
    logic w_full;
    logic w_push;

    always_comb begin
        w_s     = ~i_cfr_th;
        w_empty = (r_cnt == '0);
        w_full  = (r_cnt == (B_AW+1)'(B_DEPTH));
        w_iss_a = r_a_pend[w_s];
        w_iss_b = ~w_iss_a & ~w_empty & (r_b_th[r_rd] == w_s);
        w_push  = io_req.b_stb & ~w_full;
    end

    // ack is gated by rst_n so every output reads 0 while reset is held
    assign io_req.b_ack = w_push & rst_n;
    assign o_ia_wen     = w_iss_a;
    assign o_ia_flags   = w_iss_a ? r_a_val[w_s] : '0;
    assign o_ib_wen     = w_iss_b;
    assign o_ib_flags   = w_iss_b ? ((r_prev & ~r_b_clr[r_rd]) | r_b_set[r_rd]) : '0;
    assign o_a_ovr      = r_a_ovr;
    assign o_b_cnt      = r_cnt;
    assign o_busy       = (|r_a_pend) | ~w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_pend   <= '0;
            r_a_val[0] <= '0;
            r_a_val[1] <= '0;
            r_prev     <= '0;
            r_a_ovr    <= 1'b0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_cnt      <= '0;
        end else begin
            r_prev  <= i_cfr_flags;
            r_a_ovr <= io_req.a_stb & r_a_pend[io_req.a_th] & ~(w_iss_a & (io_req.a_th == w_s));
            // a new request for the slot thread re-arms pending even while the old value issues
            for (int t = 0; t < 2; t++) begin
                if (io_req.a_stb && io_req.a_th == 1'(t)) begin
                    r_a_pend[t] <= 1'b1;
                    r_a_val[t]  <= io_req.a_flags;
                end else if (w_iss_a && w_s == 1'(t)) begin
                    r_a_pend[t] <= 1'b0;
                end
            end
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_iss_b) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (B_AW+1)'(w_push) - (B_AW+1)'(w_iss_b);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && rst_n) begin
            r_b_th[r_wr]  <= io_req.b_th;
            r_b_set[r_wr] <= io_req.b_set;
            r_b_clr[r_wr] <= io_req.b_clr;
        end
    end
endmodule

// File: tb/tb_eco32_core_mpu_cfr_ctl.sv
// tb_eco32_core_mpu_cfr_ctl: directed tests of slot alignment, B read-modify-write, FIFO limits and overrun.
module tb_eco32_core_mpu_cfr_ctl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfr_th = 1'b0;
    logic        tog = 1'b0;
    logic        ld = 1'b0;
    logic        ld_th = 1'b0;
    logic [15:0] ld_val = '0;
    logic [15:0] ring [2];
    logic [15:0] cfr_flags;
    logic        ia_wen, ib_wen, a_ovr, busy;
    logic [15:0] ia_flags, ib_flags;
    logic [2:0]  b_cnt;
    int          checks = 0;
    int          errors = 0;

    eco32_core_mpu_cfr_ctl_if bif ();

    eco32_core_mpu_cfr_ctl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cfr_th    (cfr_th),
        .i_cfr_flags (cfr_flags),
        .io_req      (bif),
        .o_ia_wen    (ia_wen),
        .o_ia_flags  (ia_flags),
        .o_ib_wen    (ib_wen),
        .o_ib_flags  (ib_flags),
        .o_a_ovr     (a_ovr),
        .o_b_cnt     (b_cnt),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    // Ring model: slot thread is ~cfr_th; a write lands at the edge closing the cycle.
    assign cfr_flags = ring[cfr_th];
    always @(posedge clk) begin
        if (ld) ring[ld_th] <= ld_val;
        else if (ia_wen) ring[~cfr_th] <= ia_flags;
        else if (ib_wen) ring[~cfr_th] <= ib_flags;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end within time limit");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (tog) cfr_th = ~cfr_th;
    endtask

    task automatic idle();
        bif.a_stb = 1'b0; bif.a_th = 1'b0; bif.a_flags = '0;
        bif.b_stb = 1'b0; bif.b_th = 1'b0; bif.b_set = '0; bif.b_clr = '0;
    endtask

    task automatic wait_th(input logic th);
        for (int i = 0; i < 2 && cfr_th !== th; i++) cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tog = 1'b1;
        bif.a_stb = 1'b1; bif.a_th = 1'b0; bif.a_flags = 16'hFFFF;
        bif.b_stb = 1'b1; bif.b_th = 1'b0; bif.b_set = 16'hFFFF; bif.b_clr = '0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            ld = 1'b1; ld_th = 1'(i); ld_val = '0;
        end
        ld = 1'b0;
        #1;
        checks++; if (bif.b_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %0b exp 0", bif.b_ack); end
        checks++; if ({ia_wen, ib_wen, a_ovr, busy} !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b exp 0000", {ia_wen, ib_wen, a_ovr, busy}); end
        checks++; if ({ia_flags, ib_flags, b_cnt} !== '0) begin errors++; $display("FAIL rst_data: got %h exp 0", {ia_flags, ib_flags, b_cnt}); end
        idle();
        cyc();
        rst_n = 1'b1;
        cyc(); #1;
        checks++; if (b_cnt !== 3'd0) begin errors++; $display("FAIL rst_cnt: got %0d exp 0", b_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b exp 0", busy); end
    endtask

    task automatic test_a_align();
        int pulses = 0;
        tog = 1'b1;
        wait_th(1'b0);
        bif.a_stb = 1'b1; bif.a_th = 1'b0; bif.a_flags = 16'h00A5;
        #1;
        checks++; if (ia_wen !== 1'b0) begin errors++; $display("FAIL align_early: got %0b exp 0", ia_wen); end
        cyc(); idle(); #1;
        checks++; if (ia_wen !== 1'b1) begin errors++; $display("FAIL align_wen: got %0b exp 1", ia_wen); end
        checks++; if (ia_flags !== 16'h00A5) begin errors++; $display("FAIL align_data: got %h exp 00a5", ia_flags); end
        checks++; if (ib_wen !== 1'b0) begin errors++; $display("FAIL align_ib: got %0b exp 0", ib_wen); end
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            if (ia_wen) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL align_single: got %0d extra pulses exp 0", pulses); end
    endtask

    task automatic test_b_rmw();
        ld = 1'b1; ld_th = 1'b1; ld_val = 16'h0F0F;
        cyc(); ld = 1'b0;
        cyc(); cyc();
        wait_th(1'b0);
        bif.b_stb = 1'b1; bif.b_th = 1'b1; bif.b_set = 16'h1000; bif.b_clr = 16'h000F;
        #1;
        checks++; if (bif.b_ack !== 1'b1) begin errors++; $display("FAIL rmw_ack: got %0b exp 1", bif.b_ack); end
        cyc(); idle(); #1;
        checks++; if (ib_wen !== 1'b0) begin errors++; $display("FAIL rmw_wrong_slot: got %0b exp 0", ib_wen); end
        checks++; if (b_cnt !== 3'd1) begin errors++; $display("FAIL rmw_cnt1: got %0d exp 1", b_cnt); end
        cyc(); #1;
        checks++; if (ib_wen !== 1'b1) begin errors++; $display("FAIL rmw_wen: got %0b exp 1", ib_wen); end
        checks++; if (ib_flags !== 16'h1F00) begin errors++; $display("FAIL rmw_data: got %h exp 1f00", ib_flags); end
        cyc(); #1;
        checks++; if (b_cnt !== 3'd0) begin errors++; $display("FAIL rmw_cnt0: got %0d exp 0", b_cnt); end
    endtask

    task automatic test_collide();
        tog = 1'b1;
        wait_th(1'b0);
        bif.a_stb = 1'b1; bif.a_th = 1'b0; bif.a_flags = 16'h1234;
        bif.b_stb = 1'b1; bif.b_th = 1'b0; bif.b_set = 16'h0011; bif.b_clr = 16'h0010;
        #1;
        checks++; if (bif.b_ack !== 1'b1) begin errors++; $display("FAIL col_ack: got %0b exp 1", bif.b_ack); end
        cyc(); idle(); #1;
        checks++; if ({ia_wen, ib_wen} !== 2'b10) begin errors++; $display("FAIL col_first: got %b exp 10", {ia_wen, ib_wen}); end
        checks++; if (ia_flags !== 16'h1234) begin errors++; $display("FAIL col_adata: got %h exp 1234", ia_flags); end
        cyc(); #1;
        checks++; if ({ia_wen, ib_wen} !== 2'b00) begin errors++; $display("FAIL col_gap: got %b exp 00", {ia_wen, ib_wen}); end
        cyc(); #1;
        checks++; if ({ia_wen, ib_wen} !== 2'b01) begin errors++; $display("FAIL col_second: got %b exp 01", {ia_wen, ib_wen}); end
        checks++; if (ib_flags !== 16'h1235) begin errors++; $display("FAIL col_bdata: got %h exp 1235", ib_flags); end
        cyc();
    endtask

    task automatic test_full();
        int n = 0;
        tog = 1'b0; cfr_th = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bif.b_stb = 1'b1; bif.b_th = 1'b1; bif.b_set = 16'h0001 << i; bif.b_clr = '0;
            #1;
            checks++; if (bif.b_ack !== (i < 4)) begin errors++; $display("FAIL full_ack%0d: got %0b exp %0b", i, bif.b_ack, i < 4); end
            if (i < 4) cyc();
        end
        checks++; if (b_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt: got %0d exp 4", b_cnt); end
        tog = 1'b1;
        cyc(); #1;
        checks++; if ({ib_wen, bif.b_ack} !== 2'b10) begin errors++; $display("FAIL full_pop: got %b exp 10", {ib_wen, bif.b_ack}); end
        checks++; if (ib_flags !== 16'h1F01) begin errors++; $display("FAIL full_pdata: got %h exp 1f01", ib_flags); end
        bif.b_stb = 1'b0;
        cyc(); #1;
        checks++; if (b_cnt !== 3'd3) begin errors++; $display("FAIL full_cnt3: got %0d exp 3", b_cnt); end
        cyc();
        bif.b_stb = 1'b1; bif.b_set = 16'h0020;
        #1;
        checks++; if ({ib_wen, bif.b_ack} !== 2'b11) begin errors++; $display("FAIL full_pp: got %b exp 11", {ib_wen, bif.b_ack}); end
        cyc(); idle(); #1;
        checks++; if (b_cnt !== 3'd3) begin errors++; $display("FAIL full_ppcnt: got %0d exp 3", b_cnt); end
        while (busy === 1'b1 && n < 20) begin
            cyc(); n++;
        end
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_drain: got busy %0b exp 0", busy); end
    endtask

    task automatic test_overrun();
        int pulses = 0;
        tog = 1'b0; cfr_th = 1'b1;
        bif.a_stb = 1'b1; bif.a_th = 1'b1; bif.a_flags = 16'h1111;
        #1;
        checks++; if (a_ovr !== 1'b0) begin errors++; $display("FAIL ovr_pre: got %0b exp 0", a_ovr); end
        cyc();
        bif.a_flags = 16'h2222;
        #1;
        checks++; if (a_ovr !== 1'b0) begin errors++; $display("FAIL ovr_first: got %0b exp 0", a_ovr); end
        cyc(); idle(); #1;
        checks++; if ({a_ovr, ia_wen} !== 2'b10) begin errors++; $display("FAIL ovr_pulse: got %b exp 10", {a_ovr, ia_wen}); end
        tog = 1'b1;
        cyc();
        bif.a_stb = 1'b1; bif.a_th = 1'b1; bif.a_flags = 16'h3333;
        #1;
        checks++; if ({a_ovr, ia_wen} !== 2'b01) begin errors++; $display("FAIL ovr_issue: got %b exp 01", {a_ovr, ia_wen}); end
        checks++; if (ia_flags !== 16'h2222) begin errors++; $display("FAIL ovr_data: got %h exp 2222", ia_flags); end
        cyc(); idle(); #1;
        checks++; if ({a_ovr, ia_wen} !== 2'b00) begin errors++; $display("FAIL ovr_rearm: got %b exp 00", {a_ovr, ia_wen}); end
        cyc(); #1;
        checks++; if (ia_flags !== 16'h3333 || ia_wen !== 1'b1) begin errors++; $display("FAIL ovr_rearm_data: got %0b/%h exp 1/3333", ia_wen, ia_flags); end
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            if (ia_wen || a_ovr) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL ovr_quiet: got %0d extra pulses exp 0", pulses); end
    endtask

    task automatic test_reset_mid();
        tog = 1'b0; cfr_th = 1'b1;
        bif.a_stb = 1'b1; bif.a_th = 1'b1; bif.a_flags = 16'hBEEF;
        bif.b_stb = 1'b1; bif.b_th = 1'b1; bif.b_set = 16'h0001;
        cyc(); #1;
        checks++; if (busy !== 1'b1 || b_cnt !== 3'd1) begin errors++; $display("FAIL mid_busy: got %0b/%0d exp 1/1", busy, b_cnt); end
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, bif.b_ack, b_cnt} !== 5'b0) begin errors++; $display("FAIL mid_rst: got %b exp 00000", {busy, bif.b_ack, b_cnt}); end
        idle();
        cyc();
        rst_n = 1'b1; tog = 1'b1;
        cyc(); cyc(); #1;
        checks++; if ({busy, ia_wen, ib_wen} !== 3'b0) begin errors++; $display("FAIL mid_after: got %b exp 000", {busy, ia_wen, ib_wen}); end
    endtask

    initial begin
        idle();
        test_reset();
        test_a_align();
        test_b_rmw();
        test_collide();
        test_full();
        test_overrun();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
